fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream drain stage for the 16-bit register FIFO. Pops one word at a time when the FIFO is
//   non-empty and serialises it as two 8N1 UART frames (optional even parity), low byte first.
//   Sits between the FIFO read port (r_en/empty/data_out) and the board TX pin.
// PARAMETERS
//   DATA_W        16   FIFO word width; fixed at 16 (two bytes per word)
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//   PARITY_EN     0    1 = insert even parity bit between data bit 7 and stop bit
// PORTS
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   tx_en       in   1       1 = permit new FIFO reads; sampled in IDLE only
//   fifo_empty  in   1       FIFO empty flag
//   fifo_data   in   DATA_W  FIFO registered read data
//   fifo_r_en   out  1       FIFO read strobe, registered, one-cycle pulse per word
//   tx          out  1       UART serial line, idle high
//   busy        out  1       1 from REQ until last stop bit of the word completes
// BEHAVIOUR
//   - Reset (async): state=IDLE, tx=1, busy=0, fifo_r_en=0, counters=0, holding reg cleared.
//   - FSM: IDLE -> REQ -> LATCH -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE).
//   - IDLE: tx=1. If tx_en && !fifo_empty at a clk edge -> REQ; fifo_r_en=1 for exactly that cycle.
//   - REQ: FIFO captures the read on the edge ending REQ; fifo_data valid the cycle after -> LATCH.
//   - LATCH: word_q <= fifo_data at the edge ending LATCH; byte_sel=0 -> START.
//   - START: tx=0 for CLKS_PER_BIT cycles. DATA: 8 bits, LSB first, CLKS_PER_BIT each.
//   - PARITY (PARITY_EN=1 only): tx = ^byte (even parity: total ones incl. parity is even).
//   - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_sel=0 -> byte_sel=1, START with word_q[15:8]
//     (no idle gap between bytes). If byte_sel=1 -> IDLE, busy falls on the same edge.
//   - Bit timer: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); tick on terminal count,
//     counter clears on every state change; bit index 0..7 wraps to 0 on leaving DATA.
//   - Word period = 2 + 2*(10+PARITY_EN)*CLKS_PER_BIT cycles; min 3 idle-high cycles between words
//     (STOP->IDLE->REQ->LATCH) when the FIFO stays non-empty.
//   - FIFO empty flag lags the count by up to 2 cycles; fifo_empty is only examined in IDLE, which
//     is >= 20 cycles after the previous read, so no over-read of an empty FIFO is possible.
//   - tx_en falling mid-word: current word (both bytes) completes; no new read afterwards.
//   - tx_en / fifo_empty changes outside IDLE: ignored.
//   - Reset mid-frame: tx returns to 1 immediately (async), word in flight is discarded; the next
//     read after release fetches the next FIFO word. Truncated frame is acceptable on the line.
//   - busy=1 in REQ, LATCH, START, DATA, PARITY, STOP; 0 in IDLE.
// STRUCTURE
//   - Shared package fifo_uart_pkg: state enum localparams (S_IDLE, S_REQ, S_LATCH, S_START,
//     S_DATA, S_PARITY, S_STOP), UART_IDLE_LVL=1'b1, BITS_PER_BYTE=8, default CLKS_PER_BIT.
//   - One sub-module: uart_bit_timer (CLKS_PER_BIT param; inputs clk, reset, clear; output tick).
//   - Top holds FSM, word_q, byte_sel, bit index, shift register and registered tx/fifo_r_en.
// TESTING  (CLKS_PER_BIT=4 unless stated; bench uses behavioural FIFO model with 1-cycle read)
//   1. Assert reset, toggle clk -> tx=1, busy=0, fifo_r_en=0; hold reset mid-run -> same within 0 cycles.
//   2. Load 16'hA55A, tx_en=1 -> one fifo_r_en pulse; tx frames 0x5A then 0xA5, 80 cycles of
//      frame, busy high from REQ to last stop edge.
//   3. PARITY_EN=1, word 16'h0301 -> byte 0x01 parity=1, byte 0x03 parity=0; 88-cycle frame.
//   4. FIFO holds 3 words -> exactly 3 r_en pulses, 3 idle-high cycles between words, 4th
//      read never issued after FIFO empties.
//   5. tx_en=0 with FIFO non-empty -> no r_en, tx=1; drop tx_en during byte 0 -> byte 1 still
//      sent, no further read.
//   6. Reset asserted during data bit 3 of byte 1 -> tx=1, busy=0 same cycle; after release,
//      next transmitted word is the following FIFO entry.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain stage.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LATCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic UART_IDLE_LVL    = 1'b1;
    localparam int   BITS_PER_BYTE    = 8;
    localparam int   CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
// No latency beyond the counter register; clear restarts the period on the next edge.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == TERMINAL)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TERMINAL);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains 16-bit FIFO words onto a UART line as two 8N1 (optionally even-parity) frames, low byte first.
// Word occupies 2 + 2*(10+PARITY_EN)*CLKS_PER_BIT cycles; the FIFO is only read from IDLE when tx_en is set.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    output logic              tx,
    output logic              busy
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    state_t            state;
    state_t            next_state;
    logic              tick;
    logic              tx_d;
    logic              r_en_d;
    logic              par_bit;
    logic [DATA_W-1:0] word_q;
    logic              byte_sel;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    // Any state change restarts the bit period so every bit gets a full CLKS_PER_BIT.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .clear(next_state != state),
        .tick (tick)
    );

    assign par_bit = ^(byte_sel ? word_q[DATA_W-1 -: 8] : word_q[7:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tx        <= UART_IDLE_LVL;
            busy      <= 1'b0;
            fifo_r_en <= 1'b0;
        end else begin
            state     <= next_state;
            tx        <= tx_d;
            busy      <= (next_state != S_IDLE);
            fifo_r_en <= r_en_d;
        end
    end

    // tx is registered from the next-state decision so the line changes with the state.
    always_comb begin
        next_state = state;
        tx_d       = tx;
        r_en_d     = 1'b0;
        case (state)
            S_IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (tx_en && !fifo_empty) begin
                    next_state = S_REQ;
                    r_en_d     = 1'b1;
                end
            end
            S_REQ: begin
                next_state = S_LATCH;
            end
            S_LATCH: begin
                next_state = S_START;
                tx_d       = 1'b0;
            end
            S_START: begin
                if (tick) begin
                    next_state = S_DATA;
                    tx_d       = shreg[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        if (PARITY_EN) begin
                            next_state = S_PARITY;
                            tx_d       = par_bit;
                        end else begin
                            next_state = S_STOP;
                            tx_d       = UART_IDLE_LVL;
                        end
                    end else begin
                        tx_d = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    next_state = S_STOP;
                    tx_d       = UART_IDLE_LVL;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!byte_sel) begin
                        next_state = S_START;
                        tx_d       = 1'b0;
                    end else begin
                        next_state = S_IDLE;
                        tx_d       = UART_IDLE_LVL;
                    end
                end
            end
            default: begin
                next_state = S_IDLE;
                tx_d       = UART_IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q   <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_LATCH: begin
                    word_q   <= fifo_data;
                    byte_sel <= 1'b0;
                    bit_idx  <= '0;
                    shreg    <= fifo_data[7:0];
                end
                S_DATA: begin
                    if (tick) begin
                        bit_idx <= (bit_idx == LAST_BIT) ? 3'd0 : bit_idx + 3'd1;
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                end
                S_STOP: begin
                    if (tick && !byte_sel) begin
                        byte_sel <= 1'b1;
                        shreg    <= word_q[DATA_W-1 -: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_en;
    logic        tx [2];
    logic        busy [2];
    logic        fifo_r_en [2];
    logic        fifo_empty [2];

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];

    bit          end_req = 1'b0;
    int          tmo_req = 0;

    // monitor-owned state
    int          n_checks = 0;
    int          n_pass = 0;
    int          tmo_seen = 0;
    bit          in_frame [2] = '{0, 0};
    int          cyc [2] = '{0, 0};
    logic [10:0] bits [2];
    bit          stable [2] = '{1, 1};
    bit          word_active [2] = '{0, 0};
    int          bytes_done [2] = '{0, 0};
    bit          prev_busy [2] = '{0, 0};
    bit          prev_cond [2] = '{0, 0};
    int          run_len [2] = '{0, 0};

    always #5 clk = ~clk;

    // Lane 0 runs 8N1, lane 1 runs with even parity; both drain identical FIFO contents.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        int          rd_ptr = 0;
        logic [15:0] fifo_data_l = '0;

        assign fifo_empty[g] = (rd_ptr == wr_ptr);

        always @(posedge clk) begin
            if (fifo_r_en[g]) begin
                fifo_data_l <= mem[rd_ptr[7:0]];
                rd_ptr      <= rd_ptr + 1;
            end
        end

        fifo_uart_tx #(
            .DATA_W      (16),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (g == 1)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .tx_en     (tx_en),
            .fifo_empty(fifo_empty[g]),
            .fifo_data (fifo_data_l),
            .fifo_r_en (fifo_r_en[g]),
            .tx        (tx[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic pop_exp(input int d, output logic [7:0] v, output bit ok);
        ok = 1'b0;
        v  = 8'h00;
        if (d == 0) begin
            if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
        end else begin
            if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic finish_frame(input int d);
        int         f = 10 + d;
        logic [7:0] b = bits[d][8:1];
        logic [7:0] e;
        bit         ok;
        bit         fmt = stable[d] && (bits[d][0] == 1'b0) && (bits[d][f-1] == 1'b1);
        if (d == 1) fmt = fmt && (bits[d][9] == ^b);
        check($sformatf("frame_fmt%0d", d), {31'd0, fmt}, 32'd1);
        pop_exp(d, e, ok);
        if (!ok) check($sformatf("unexpected_byte%0d", d), {24'd0, b}, 32'hFFFF_FFFF);
        else     check($sformatf("byte%0d", d), {24'd0, b}, {24'd0, e});
        bytes_done[d]++;
        if (bytes_done[d] == 2) word_active[d] = 1'b0;
    endtask

    task automatic lane(input int d);
        logic [7:0] junk;
        bit         ok;
        if (reset) begin
            check($sformatf("rst_tx%0d", d), {31'd0, tx[d]}, 32'd1);
            check($sformatf("rst_busy%0d", d), {31'd0, busy[d]}, 32'd0);
            check($sformatf("rst_r_en%0d", d), {31'd0, fifo_r_en[d]}, 32'd0);
            if (word_active[d]) begin
                for (int k = bytes_done[d]; k < 2; k++) pop_exp(d, junk, ok);
            end
            word_active[d] = 1'b0;
            in_frame[d]    = 1'b0;
            prev_busy[d]   = 1'b0;
            prev_cond[d]   = 1'b0;
            run_len[d]     = 0;
            return;
        end
        if (prev_cond[d] || fifo_r_en[d])
            check($sformatf("r_en%0d", d), {31'd0, fifo_r_en[d]}, {31'd0, prev_cond[d]});
        if (fifo_r_en[d]) begin
            check($sformatf("busy_at_req%0d", d), {31'd0, busy[d]}, 32'd1);
            word_active[d] = 1'b1;
            bytes_done[d]  = 0;
        end
        if (!busy[d]) check($sformatf("idle_tx%0d", d), {31'd0, tx[d]}, 32'd1);
        if (busy[d]) begin
            run_len[d]++;
        end else if (prev_busy[d]) begin
            check($sformatf("busy_len%0d", d), run_len[d], 2 + 2 * (10 + d) * CPB);
            run_len[d] = 0;
        end
        prev_busy[d] = busy[d];
        prev_cond[d] = !busy[d] && tx_en && !fifo_empty[d];

        if (!in_frame[d] && tx[d] == 1'b0) begin
            in_frame[d] = 1'b1;
            cyc[d]      = 0;
            bits[d]     = '0;
            stable[d]   = 1'b1;
        end
        if (in_frame[d]) begin
            if (cyc[d] % CPB == 0) bits[d][cyc[d] / CPB] = tx[d];
            else if (tx[d] != bits[d][cyc[d] / CPB]) stable[d] = 1'b0;
            cyc[d]++;
            if (cyc[d] == (10 + d) * CPB) begin
                in_frame[d] = 1'b0;
                finish_frame(d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tmo_req != tmo_seen) begin
            check("wait_timeout", tmo_req, tmo_seen);
            tmo_seen = tmo_req;
        end
        if (end_req) begin
            check("drain_q0", exp_q0.size(), 0);
            check("drain_q1", exp_q1.size(), 0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end else begin
            for (int d = 0; d < 2; d++) lane(d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] w);
        mem[wr_ptr[7:0]] = w;
        exp_q0.push_back(w[7:0]);
        exp_q0.push_back(w[15:8]);
        exp_q1.push_back(w[7:0]);
        exp_q1.push_back(w[15:8]);
        wr_ptr++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(!busy[0] && !busy[1] && (fifo_empty[0] || !tx_en) && (fifo_empty[1] || !tx_en))
               && n < budget) begin
            cycles(1);
            n++;
        end
        if (n >= budget) tmo_req++;
        cycles(2);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy[0] && n < budget) begin
            cycles(1);
            n++;
        end
        if (n >= budget) tmo_req++;
    endtask

    initial begin
        reset = 1'b1;
        tx_en = 1'b0;
        cycles(4);
        reset = 1'b0;
        cycles(2);

        load(16'hA55A);
        tx_en = 1'b1;
        wait_idle(400);

        load(16'h0301);
        wait_idle(400);

        load(16'h1234);
        load(16'($urandom));
        load(16'($urandom));
        wait_idle(1000);

        tx_en = 1'b0;
        load(16'($urandom));
        load(16'($urandom));
        cycles(60);
        tx_en = 1'b1;
        wait_busy(20);
        cycles(2 + CPB * 5);
        tx_en = 1'b0;
        wait_idle(400);
        cycles(30);
        tx_en = 1'b1;
        wait_idle(400);

        // reset during data bit 3 of the high byte on lane 0
        load(16'($urandom));
        load(16'($urandom));
        wait_busy(20);
        cycles(2 + 10 * CPB + 4 * CPB + 1);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        wait_idle(600);

        for (int it = 0; it < 6; it++) begin
            int nw = int'($urandom_range(1, 3));
            for (int k = 0; k < nw; k++) load(16'($urandom));
            tx_en = ($urandom_range(0, 3) != 0);
            cycles(int'($urandom_range(5, 150)));
            tx_en = ($urandom_range(0, 1) != 0);
            cycles(int'($urandom_range(5, 120)));
        end
        tx_en = 1'b1;
        wait_idle(4000);

        end_req = 1'b1;
        cycles(5);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
